// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - iterative multiply/divide unit with HI/LO registers and pipeline stall
//
// Purpose: executes MULT/MULTU/DIV/DIVU over ITER cycles, one shift-add or
// restoring shift-subtract step per cycle, then one sign-fixup cycle that
// commits HI/LO. MTHI/MTLO write HI/LO directly. The stall output holds the
// pipeline while an op is in flight and another MDU op or MFHI/MFLO arrives.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start_valid, op    MDU op from execute (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   src_a, src_b       rs / rt operands
//   mf_req             MFHI/MFLO read request this cycle
//   flush              abort in-flight op, ignore this cycle's start
//   stall              hold the pipeline this cycle
//   busy               iterative op in flight (BUSY or FIXUP)
//   done               one-cycle pulse after a mul/div commit
//   hi, lo             HI/LO registers
module mdu_sched #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mf_req,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [XLEN-1:0]   mreg;
  logic [XLEN-1:0]   a_raw;
  logic              is_div;
  logic              neg_lo;   // product sign (mul) or quotient sign (div)
  logic              neg_hi;   // remainder sign (div only)
  logic              div0;

  logic              md_op;
  logic              is_signed;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign md_op     = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
  assign is_signed = (op == 3'd1) || (op == 3'd3);
  assign a_mag     = (is_signed && src_a[XLEN-1]) ? -src_a : src_a;
  assign b_mag     = (is_signed && src_b[XLEN-1]) ? -src_b : src_b;

  assign busy  = (state != IDLE);
  assign stall = busy & (start_valid | mf_req);

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole {product, multiplier} pair right by one.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mreg} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the difference only when it did not go negative.
  assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff     = rem_sh - {1'b0, mreg};
  assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};

  assign prod_fix = neg_lo ? -acc : acc;
  assign q_fix    = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r_fix    = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_valid && md_op && !flush) state_nx = BUSY;
      BUSY:    if (flush) state_nx = IDLE;
               else if (cnt == CW'(1)) state_nx = FIXUP;
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      acc    <= '0;
      mreg   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid && !flush) begin
            if (md_op) begin
              is_div <= (op == 3'd3) || (op == 3'd4);
              a_raw  <= src_a;
              div0   <= (src_b == '0);
              neg_lo <= is_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
              neg_hi <= is_signed && src_a[XLEN-1];
              cnt    <= CW'(ITER);
              if ((op == 3'd3) || (op == 3'd4)) begin
                mreg <= b_mag;
                acc  <= {{XLEN{1'b0}}, a_mag};
              end else begin
                mreg <= a_mag;
                acc  <= {{XLEN{1'b0}}, b_mag};
              end
            end else if (op == 3'd5) begin
              hi <= src_a;
            end else if (op == 3'd6) begin
              lo <= src_a;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CW'(1);
          end
        end
        FIXUP: begin
          // Flush wins over the commit: HI/LO stay untouched and no done pulse.
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end else if (div0) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - directed scoreboard bench for mdu_sched
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        mf_req = 1'b0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  mdu_sched #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .resetn(resetn), .start_valid(start_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .mf_req(mf_req), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r64;
    int q, r;
    r64 = '0;
    case (o)
      3'd1: r64 = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'd2: r64 = {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 32'd0) r64 = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r64 = {32'h0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          r64 = {r, q};
        end
      end
      3'd4: begin
        if (b == 32'd0) r64 = {a, 32'hFFFFFFFF};
        else r64 = {a % b, a / b};
      end
      default: r64 = '0;
    endcase
    return r64;
  endfunction

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit with_mf);
    exp_t e;
    int n, nostall;
    e = model(o, a, b);
    sb.push_back(e);
    tq.push_back(tag);
    start_valid = 1'b1; op = o; src_a = a; src_b = b; mf_req = with_mf;
    tick();
    start_valid = 1'b0; op = 3'd0;
    n = 0; nostall = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (with_mf && stall !== 1'b1) nostall++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    if (with_mf) begin
      chk({tag, "_stall_busy_gaps"}, 64'(nostall), 64'd0);
      chk({tag, "_stall_idle"}, {63'b0, stall}, 64'd0);
    end
    mf_req = 1'b0;
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    e = sb.pop_front();
    chk({tq.pop_front(), "_hilo"}, {hi, lo}, e);
    last_hi = e.hi; last_lo = e.lo;
    tick();
    chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    exp_t e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tick(); tick();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    resetn = 1'b1;
    tick();

    run_md(3'd1, 32'hFFFFFFFD, 32'd7, "mult_neg3x7", 1'b0);
    chk("mult_const", {last_hi, last_lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b1);
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, "div_m7_2", 1'b0);
    run_md(3'd4, 32'd100, 32'd0, "divu_by0", 1'b0);
    run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);
    run_md(3'd3, 32'h12345678, 32'd0, "div_by0", 1'b0);

    // MTHI then MTLO back to back: no stall, each lands at its own edge.
    e = '{hi: 32'h12345678, lo: last_lo};
    sb.push_back(e); tq.push_back("mthi");
    start_valid = 1'b1; op = 3'd5; src_a = 32'h12345678;
    #1 chk("mthi_stall", {63'b0, stall}, 64'd0);
    tick();
    e = sb.pop_front();
    chk({tq.pop_front(), "_hilo"}, {hi, lo}, e);
    e = '{hi: 32'h12345678, lo: 32'h9ABCDEF0};
    sb.push_back(e); tq.push_back("mtlo");
    op = 3'd6; src_a = 32'h9ABCDEF0;
    #1 chk("mtlo_stall", {63'b0, stall}, 64'd0);
    tick();
    start_valid = 1'b0; op = 3'd0;
    e = sb.pop_front();
    chk({tq.pop_front(), "_hilo"}, {hi, lo}, e);
    last_hi = e.hi; last_lo = e.lo;

    // DIVU flushed in BUSY cycle 10, with a start presented alongside the flush.
    start_valid = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start_valid = 1'b0; op = 3'd0;
    repeat (9) tick();
    chk("flush_pre_busy", {63'b0, busy}, 64'd1);
    flush = 1'b1; start_valid = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd5;
    tick();
    flush = 1'b0; start_valid = 1'b0; op = 3'd0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, {last_hi, last_lo});
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) break;
      tick();
    end
    chk("flush_no_done", {62'b0, done, busy}, 64'd0);

    // Flush in IDLE blocks both a mul/div start and an MT write.
    flush = 1'b1; start_valid = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd9;
    tick();
    chk("flush_idle_start", {63'b0, busy}, 64'd0);
    op = 3'd5; src_a = 32'hDEADBEEF;
    tick();
    flush = 1'b0; start_valid = 1'b0; op = 3'd0;
    chk("flush_idle_mt", {hi, lo}, {last_hi, last_lo});

    // Reset in BUSY cycle 20 of a MULT.
    start_valid = 1'b1; op = 3'd1; src_a = 32'd123; src_b = 32'd456;
    tick();
    start_valid = 1'b0; op = 3'd0;
    repeat (19) tick();
    resetn = 1'b0; mf_req = 1'b1;
    tick();
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_stall", {63'b0, stall}, 64'd0);
    resetn = 1'b1; mf_req = 1'b0;
    tick();
    run_md(3'd1, 32'hFFFFFF85, 32'd1000, "mult_after_rst", 1'b0);

    for (int i = 0; i < 4; i++) begin
      ro = 3'(1 + (i % 4));
      ra = $urandom;
      rb = (i == 3) ? 32'(($urandom % 97) + 1) : $urandom;
      run_md(ro, ra, rb, "rand_md", 1'b0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
